// File: rtl/gpu_sched_pkg.sv
// Shared types for the thread dispatcher: per-unit state encoding and the launch request record.
package gpu_sched_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    FU_IDLE  = 2'b00,
    FU_START = 2'b01,
    FU_RUN   = 2'b10
  } fu_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mem_addr;
  } launch_req_t;

  // Modulo increment used for the round-robin pointer.
  function automatic int unsigned wrap_inc(int unsigned v, int unsigned n);
    return (v + 1) % n;
  endfunction

endpackage

// File: rtl/sched_fifo.sv
// Launch request FIFO with wrap-bit pointers and synchronous reset.
module sched_fifo
  import gpu_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(launch_req_t)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Full when the index bits agree but the wrap bits differ.
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/fu_dispatch_sched.sv
// Round-robin thread dispatcher in front of NUM_FU func_units.
// Optional macro SCHED_PERF_EN adds launch/stall/completion performance counters.
//
// state    | meaning
// FU_IDLE  | unit free, eligible for dispatch
// FU_START | one-cycle fu_start pulse, arm counter loads
// FU_RUN   | thread running; complete honoured only once arm counter is 0
module fu_dispatch_sched
  import gpu_sched_pkg::*;
#(
  parameter int NUM_FU     = 4,
  parameter int QDEPTH     = 4,
  parameter int ARM_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     launch_valid,
  output logic                     launch_ready,
  input  logic [ADDR_W-1:0]        launch_pc,
  input  logic [ADDR_W-1:0]        launch_mem_addr,
  output logic [NUM_FU-1:0]        fu_start,
  output logic [ADDR_W*NUM_FU-1:0] fu_starting_pc,
  output logic [ADDR_W*NUM_FU-1:0] fu_init_mem_addr,
  input  logic [NUM_FU-1:0]        fu_thread_complete,
  output logic [NUM_FU-1:0]        done_mask,
  output logic [NUM_FU-1:0]        busy_mask,
  output logic                     sched_idle
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0]              perf_launches,
  output logic [31:0]              perf_stall_cycles,
  output logic [31:0]              perf_completions
`endif
);

  localparam int PTR_W = $clog2(NUM_FU);
  localparam int CNT_W = $clog2(ARM_CYCLES + 1);

  launch_req_t        push_req;
  launch_req_t        head_req;
  logic               fifo_full;
  logic               fifo_empty;
  logic               dispatch;
  logic [NUM_FU-1:0]  idle_mask;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_next;
  logic [PTR_W-1:0]   sel_idx;
  logic               sel_valid;

  assign push_req.pc       = launch_pc;
  assign push_req.mem_addr = launch_mem_addr;

  sched_fifo #(
    .DEPTH(QDEPTH),
    .WIDTH($bits(launch_req_t))
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (launch_valid),
    .pop  (dispatch),
    .din  (push_req),
    .dout (head_req),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign launch_ready = !fifo_full;
  assign dispatch     = sel_valid && !fifo_empty;
  assign sched_idle   = fifo_empty && (busy_mask == '0);

  // First IDLE unit at or after rr_ptr, wrapping modulo NUM_FU.
  always_comb begin
    int unsigned      cand;
    logic [PTR_W-1:0] cand_idx;
    sel_valid = 1'b0;
    sel_idx   = '0;
    rr_next   = rr_ptr;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      cand     = (32'(rr_ptr) + 32'(k)) % NUM_FU;
      cand_idx = PTR_W'(cand);
      if (!sel_valid && idle_mask[cand_idx]) begin
        sel_valid = 1'b1;
        sel_idx   = cand_idx;
        rr_next   = PTR_W'(wrap_inc(cand, NUM_FU));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (dispatch) begin
      rr_ptr <= rr_next;
    end
  end

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    fu_state_t         state_q;
    fu_state_t         state_d;
    logic [CNT_W-1:0]  arm_cnt;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] addr_q;
    logic              chosen;
    logic              armed_done;
    logic              start_o;
    logic              done_o;
    logic              busy_o;
    logic              idle_o;

    assign chosen     = dispatch && (sel_idx == PTR_W'(g));
    assign armed_done = (arm_cnt == '0) && fu_thread_complete[g];

    always_ff @(posedge clk) begin
      if (rst) state_q <= FU_IDLE;
      else     state_q <= state_d;
    end

    // Arm counter masks the stale complete left high by the previous thread.
    always_ff @(posedge clk) begin
      if (rst) begin
        arm_cnt <= '0;
        pc_q    <= '0;
        addr_q  <= '0;
      end else begin
        if (state_q == FU_START)
          arm_cnt <= CNT_W'(ARM_CYCLES);
        else if (state_q == FU_RUN && arm_cnt != '0)
          arm_cnt <= arm_cnt - 1'b1;
        if (chosen) begin
          pc_q   <= head_req.pc;
          addr_q <= head_req.mem_addr;
        end
      end
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        FU_IDLE:  if (chosen) state_d = FU_START;
        FU_START: state_d = FU_RUN;
        FU_RUN:   if (armed_done) state_d = FU_IDLE;
        default:  state_d = FU_IDLE;
      endcase
    end

    always_comb begin
      start_o = (state_q == FU_START);
      done_o  = (state_q == FU_RUN) && armed_done;
      busy_o  = (state_q != FU_IDLE);
      idle_o  = (state_q == FU_IDLE);
    end

    assign fu_start[g]                        = start_o;
    assign done_mask[g]                       = done_o;
    assign busy_mask[g]                       = busy_o;
    assign idle_mask[g]                       = idle_o;
    assign fu_starting_pc[g*ADDR_W +: ADDR_W]   = pc_q;
    assign fu_init_mem_addr[g*ADDR_W +: ADDR_W] = addr_q;
  end

`ifdef SCHED_PERF_EN
  logic stall;
  assign stall = !fifo_empty && (idle_mask == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_launches     <= '0;
      perf_stall_cycles <= '0;
      perf_completions  <= '0;
    end else begin
      perf_launches     <= perf_launches + 32'(dispatch);
      perf_stall_cycles <= perf_stall_cycles + 32'(stall);
      perf_completions  <= perf_completions + 32'($countones(done_mask));
    end
  end
`endif

endmodule

// File: tb/tb_fu_dispatch_sched.sv
// Bench for fu_dispatch_sched: directed scenarios plus random traffic against a queue-based model.
module tb_fu_dispatch_sched;
  localparam int NUM_FU = 4;
  localparam int QDEPTH = 4;
  localparam int ARM    = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 launch_valid;
  logic                 launch_ready;
  logic [31:0]          launch_pc;
  logic [31:0]          launch_mem_addr;
  logic [NUM_FU-1:0]    fu_start;
  logic [32*NUM_FU-1:0] fu_starting_pc;
  logic [32*NUM_FU-1:0] fu_init_mem_addr;
  logic [NUM_FU-1:0]    fu_thread_complete;
  logic [NUM_FU-1:0]    done_mask;
  logic [NUM_FU-1:0]    busy_mask;
  logic                 sched_idle;
`ifdef SCHED_PERF_EN
  logic [31:0]          perf_launches;
  logic [31:0]          perf_stall_cycles;
  logic [31:0]          perf_completions;
`endif

  always #5 clk = ~clk;

  fu_dispatch_sched #(.NUM_FU(NUM_FU), .QDEPTH(QDEPTH), .ARM_CYCLES(ARM)) dut (
    .clk               (clk),
    .rst               (rst),
    .launch_valid      (launch_valid),
    .launch_ready      (launch_ready),
    .launch_pc         (launch_pc),
    .launch_mem_addr   (launch_mem_addr),
    .fu_start          (fu_start),
    .fu_starting_pc    (fu_starting_pc),
    .fu_init_mem_addr  (fu_init_mem_addr),
    .fu_thread_complete(fu_thread_complete),
    .done_mask         (done_mask),
    .busy_mask         (busy_mask),
    .sched_idle        (sched_idle)
`ifdef SCHED_PERF_EN
    ,
    .perf_launches     (perf_launches),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_completions  (perf_completions)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of pending requests and, per unit, cycles elapsed since dispatch.
  logic [63:0]       mq[$];
  bit                m_busy [NUM_FU];
  int                m_age  [NUM_FU];
  logic [31:0]       m_pc   [NUM_FU];
  logic [31:0]       m_addr [NUM_FU];
  int                m_rr;
  logic [31:0]       m_launches, m_stall, m_comp;
  logic [NUM_FU-1:0] e_start, e_done, e_busy;
  logic              e_ready, e_idle;

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < NUM_FU; i++) begin
      m_busy[i] = 0; m_age[i] = 0; m_pc[i] = '0; m_addr[i] = '0;
    end
    m_rr = 0; m_launches = '0; m_stall = '0; m_comp = '0;
  endtask

  task automatic model_eval();
    for (int i = 0; i < NUM_FU; i++) begin
      e_start[i] = m_busy[i] && (m_age[i] == 0);
      e_done[i]  = m_busy[i] && (m_age[i] >= 1 + ARM) && (fu_thread_complete[i] === 1'b1);
      e_busy[i]  = m_busy[i];
    end
    e_ready = (mq.size() < QDEPTH);
    e_idle  = (mq.size() == 0) && (e_busy == '0);
  endtask

  task automatic model_commit();
    int pick;
    bit all_busy;
    bit do_push;
    logic [63:0] req;
    model_eval();
    if (rst) begin
      model_reset();
      return;
    end
    pick = -1;
    all_busy = 1;
    for (int i = 0; i < NUM_FU; i++) if (!m_busy[i]) all_busy = 0;
    if (mq.size() > 0)
      for (int k = 0; k < NUM_FU; k++) begin
        int j = (m_rr + k) % NUM_FU;
        if (pick < 0 && !m_busy[j]) pick = j;
      end
    do_push = launch_valid && (mq.size() < QDEPTH);
    if (pick >= 0) m_launches = m_launches + 1;
    if (mq.size() > 0 && all_busy) m_stall = m_stall + 1;
    m_comp = m_comp + 32'($countones(e_done));
    for (int i = 0; i < NUM_FU; i++)
      if (m_busy[i]) begin
        if (e_done[i]) m_busy[i] = 0;
        else m_age[i]++;
      end
    if (pick >= 0) begin
      req = mq.pop_front();
      m_busy[pick] = 1; m_age[pick] = 0;
      m_pc[pick] = req[63:32]; m_addr[pick] = req[31:0];
      m_rr = (pick + 1) % NUM_FU;
    end
    if (do_push) mq.push_back({launch_pc, launch_mem_addr});
  endtask

  task automatic tick_eval();
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick_commit();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle_inputs();
    launch_valid = 0; launch_pc = '0; launch_mem_addr = '0; fu_thread_complete = '0;
  endtask

  task automatic launch(input logic [31:0] pc, input logic [31:0] addr);
    launch_valid = 1; launch_pc = pc; launch_mem_addr = addr;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    tick_eval(); tick_commit();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    tick_eval(); tick_commit();
    tick_eval();
    total++;
    if (launch_ready !== 1'b1 || sched_idle !== 1'b1 || fu_start !== '0 || busy_mask !== '0 || done_mask !== '0)
      begin bad++; $display("FAIL reset_ctrl act ready=%b idle=%b start=%b busy=%b done=%b", launch_ready, sched_idle, fu_start, busy_mask, done_mask); end
    total++;
    if (fu_starting_pc !== '0 || fu_init_mem_addr !== '0)
      begin bad++; $display("FAIL reset_addr act pc=%h addr=%h exp=0", fu_starting_pc, fu_init_mem_addr); end
`ifdef SCHED_PERF_EN
    total++;
    if (perf_launches !== 0 || perf_stall_cycles !== 0 || perf_completions !== 0)
      begin bad++; $display("FAIL reset_perf act %0d %0d %0d exp 0", perf_launches, perf_stall_cycles, perf_completions); end
`endif
    tick_commit();
    rst = 0;
  endtask

  task automatic test_single();
    do_reset();
    launch(32'h100, 32'h2000);
    tick_eval();
    total++; if (launch_ready !== 1'b1) begin bad++; $display("FAIL single_ready act=%b exp=1", launch_ready); end
    tick_commit();
    idle_inputs();
    tick_eval();
    total++; if (fu_start !== 4'b0000) begin bad++; $display("FAIL single_early act=%b exp=0000", fu_start); end
    tick_commit();
    tick_eval();
    total++; if (fu_start !== 4'b0001) begin bad++; $display("FAIL single_start act=%b exp=0001", fu_start); end
    total++;
    if (fu_starting_pc[31:0] !== 32'h100 || fu_init_mem_addr[31:0] !== 32'h2000)
      begin bad++; $display("FAIL single_pc act=%h/%h exp=100/2000", fu_starting_pc[31:0], fu_init_mem_addr[31:0]); end
    tick_commit();
    for (int c = 0; c < 4; c++) begin
      tick_eval();
      total++;
      if (done_mask !== 4'b0000 || busy_mask !== 4'b0001)
        begin bad++; $display("FAIL single_run c=%0d act done=%b busy=%b exp 0000/0001", c, done_mask, busy_mask); end
      tick_commit();
    end
    fu_thread_complete = 4'b0001;
    tick_eval();
    total++; if (done_mask !== 4'b0001) begin bad++; $display("FAIL single_done act=%b exp=0001", done_mask); end
    tick_commit();
    fu_thread_complete = '0;
    tick_eval();
    total++;
    if (busy_mask !== '0 || sched_idle !== 1'b1 || done_mask !== '0 || fu_starting_pc[31:0] !== 32'h100)
      begin bad++; $display("FAIL single_after act busy=%b idle=%b done=%b pc=%h", busy_mask, sched_idle, done_mask, fu_starting_pc[31:0]); end
    tick_commit();
  endtask

  task automatic test_back_to_back();
    logic [NUM_FU-1:0] exp_s;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c < 6) launch(32'h1000 + 32'(4 * c), 32'h8000 + 32'(16 * c));
      else idle_inputs();
      tick_eval();
      exp_s = (c >= 2 && c <= 5) ? NUM_FU'(1 << (c - 2)) : '0;
      total++; if (fu_start !== exp_s) begin bad++; $display("FAIL b2b_start c=%0d act=%b exp=%b", c, fu_start, exp_s); end
      tick_commit();
    end
    tick_eval();
    total++;
    if (busy_mask !== 4'hf || sched_idle !== 1'b0 || launch_ready !== 1'b1)
      begin bad++; $display("FAIL b2b_queued act busy=%b idle=%b ready=%b exp 1111/0/1", busy_mask, sched_idle, launch_ready); end
    tick_commit();
    fu_thread_complete = 4'b0100;
    tick_eval();
    total++; if (done_mask !== 4'b0100) begin bad++; $display("FAIL b2b_done act=%b exp=0100", done_mask); end
    tick_commit();
    fu_thread_complete = '0;
    tick_eval();
    total++; if (fu_start !== 4'b0000) begin bad++; $display("FAIL b2b_gap act=%b exp=0000", fu_start); end
    tick_commit();
    tick_eval();
    total++;
    if (fu_start !== 4'b0100 || fu_starting_pc[95:64] !== 32'h1010)
      begin bad++; $display("FAIL b2b_refill act start=%b pc=%h exp 0100/1010", fu_start, fu_starting_pc[95:64]); end
    tick_commit();
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      launch(32'h2000 + 32'(4 * c), 32'h9000 + 32'(c));
      tick_eval();
      total++; if (launch_ready !== 1'b1) begin bad++; $display("FAIL full_fill c=%0d act=%b exp=1", c, launch_ready); end
      tick_commit();
    end
    launch(32'h2099, 32'h9099);
    for (int c = 0; c < 3; c++) begin
      tick_eval();
      total++; if (launch_ready !== 1'b0) begin bad++; $display("FAIL full_hold c=%0d act=%b exp=0", c, launch_ready); end
      tick_commit();
    end
    fu_thread_complete = 4'b0001;
    tick_eval();
    total++;
    if (done_mask !== 4'b0001 || launch_ready !== 1'b0)
      begin bad++; $display("FAIL full_done act done=%b ready=%b exp 0001/0", done_mask, launch_ready); end
    tick_commit();
    fu_thread_complete = '0;
    tick_eval();
    total++; if (launch_ready !== 1'b0) begin bad++; $display("FAIL full_pop act=%b exp=0", launch_ready); end
    tick_commit();
    tick_eval();
    total++;
    if (launch_ready !== 1'b1 || fu_start !== 4'b0001 || fu_starting_pc[31:0] !== 32'h2010)
      begin bad++; $display("FAIL full_free act ready=%b start=%b pc=%h exp 1/0001/2010", launch_ready, fu_start, fu_starting_pc[31:0]); end
    tick_commit();
    idle_inputs();
    tick_eval();
    total++; if (launch_ready !== 1'b0) begin bad++; $display("FAIL full_again act=%b exp=0", launch_ready); end
    tick_commit();
  endtask

  task automatic test_arm_stale();
    logic [NUM_FU-1:0] exp_d;
    do_reset();
    fu_thread_complete = 4'b0001;
    for (int c = 0; c < 7; c++) begin
      if (c == 0) launch(32'h300, 32'h400);
      else launch_valid = 0;
      tick_eval();
      exp_d = (c == 5) ? 4'b0001 : 4'b0000;
      total++; if (done_mask !== exp_d) begin bad++; $display("FAIL arm_done c=%0d act=%b exp=%b", c, done_mask, exp_d); end
      tick_commit();
    end
    idle_inputs();
  endtask

  task automatic test_multi_complete_wrap();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c < 4) launch(32'h4000 + 32'(c), 32'h0);
      else idle_inputs();
      tick_eval(); tick_commit();
    end
    fu_thread_complete = 4'b1010;
    tick_eval();
    total++; if (done_mask !== 4'b1010) begin bad++; $display("FAIL multi_done act=%b exp=1010", done_mask); end
    tick_commit();
    fu_thread_complete = 4'b0001;
    tick_eval();
    total++;
    if (done_mask !== 4'b0001 || busy_mask !== 4'b0101)
      begin bad++; $display("FAIL multi_done0 act done=%b busy=%b exp 0001/0101", done_mask, busy_mask); end
    tick_commit();
    fu_thread_complete = '0;
    launch(32'h500, 32'h600);
    tick_eval(); tick_commit();
    launch(32'h504, 32'h604);
    tick_eval();
    total++; if (fu_start !== 4'b0000) begin bad++; $display("FAIL wrap_gap act=%b exp=0000", fu_start); end
    tick_commit();
    idle_inputs();
    tick_eval();
    total++;
    if (fu_start !== 4'b0001 || fu_starting_pc[31:0] !== 32'h500)
      begin bad++; $display("FAIL wrap_unit0 act start=%b pc=%h exp 0001/500", fu_start, fu_starting_pc[31:0]); end
    tick_commit();
    tick_eval();
    total++;
    if (fu_start !== 4'b0010 || fu_starting_pc[63:32] !== 32'h504)
      begin bad++; $display("FAIL wrap_unit1 act start=%b pc=%h exp 0010/504", fu_start, fu_starting_pc[63:32]); end
    tick_commit();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      launch_valid       = ($urandom_range(0, 99) < 60);
      launch_pc          = $urandom;
      launch_mem_addr    = $urandom;
      fu_thread_complete = NUM_FU'($urandom) & NUM_FU'($urandom);
      tick_eval();
      total++; if (fu_start !== e_start) begin bad++; $display("FAIL rnd_start c=%0d act=%b exp=%b", c, fu_start, e_start); end
      total++; if (done_mask !== e_done) begin bad++; $display("FAIL rnd_done c=%0d act=%b exp=%b", c, done_mask, e_done); end
      total++; if (busy_mask !== e_busy) begin bad++; $display("FAIL rnd_busy c=%0d act=%b exp=%b", c, busy_mask, e_busy); end
      total++;
      if (launch_ready !== e_ready || sched_idle !== e_idle)
        begin bad++; $display("FAIL rnd_flags c=%0d act ready=%b idle=%b exp %b/%b", c, launch_ready, sched_idle, e_ready, e_idle); end
      for (int i = 0; i < NUM_FU; i++) begin
        total++;
        if (fu_starting_pc[i*32 +: 32] !== m_pc[i] || fu_init_mem_addr[i*32 +: 32] !== m_addr[i])
          begin bad++; $display("FAIL rnd_addr c=%0d u=%0d act=%h/%h exp=%h/%h", c, i, fu_starting_pc[i*32 +: 32], fu_init_mem_addr[i*32 +: 32], m_pc[i], m_addr[i]); end
      end
`ifdef SCHED_PERF_EN
      total++;
      if (perf_launches !== m_launches || perf_stall_cycles !== m_stall || perf_completions !== m_comp)
        begin bad++; $display("FAIL rnd_perf c=%0d act=%0d/%0d/%0d exp=%0d/%0d/%0d", c, perf_launches, perf_stall_cycles, perf_completions, m_launches, m_stall, m_comp); end
`endif
      tick_commit();
    end
    idle_inputs();
    fu_thread_complete = '1;
    for (int c = 0; c < 40; c++) begin tick_eval(); tick_commit(); end
    tick_eval();
    total++; if (sched_idle !== 1'b1) begin bad++; $display("FAIL rnd_drain act=%b exp=1", sched_idle); end
    tick_commit();
    idle_inputs();
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c < 7) launch(32'h7000 + 32'(c), 32'h7100 + 32'(c));
      else idle_inputs();
      tick_eval(); tick_commit();
    end
    rst = 1;
    tick_eval(); tick_commit();
    rst = 0;
    fu_thread_complete = '1;
    for (int c = 0; c < 4; c++) begin
      tick_eval();
      total++;
      if (done_mask !== '0 || busy_mask !== '0 || fu_start !== '0 || launch_ready !== 1'b1 || sched_idle !== 1'b1)
        begin bad++; $display("FAIL midrst_ctrl c=%0d act done=%b busy=%b start=%b ready=%b idle=%b", c, done_mask, busy_mask, fu_start, launch_ready, sched_idle); end
      total++;
      if (fu_starting_pc !== '0 || fu_init_mem_addr !== '0)
        begin bad++; $display("FAIL midrst_addr c=%0d act=%h/%h exp=0", c, fu_starting_pc, fu_init_mem_addr); end
`ifdef SCHED_PERF_EN
      if (c == 0) begin
        total++;
        if (perf_launches !== 0 || perf_stall_cycles !== 0 || perf_completions !== 0)
          begin bad++; $display("FAIL midrst_perf act %0d %0d %0d exp 0", perf_launches, perf_stall_cycles, perf_completions); end
      end
`endif
      tick_commit();
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    rst = 1;
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_arm_stale();
    test_multi_complete_wrap();
    test_random();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
